ifu_fetch: RTL

- Instruction fetch unit that produces the 32-bit instruction word consumed by the decode stage of the NPC core.
- Owns the PC and issues one instruction-memory read at a time over a valid/ready request channel and a valid-only response channel.
- Presents each fetched word with its PC to decode over a valid/ready handshake.
- Accepts redirects (jal/jalr targets) from execute.

---
 rtl/ifu_fetch.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time, hands words to decode.
// Latency: request acceptance to inst_valid = memory latency + 1 cycle.
// Backpressure: imem_req_valid held with stable addr until accepted; inst held in HOLD until inst_ready.
module ifu_fetch #(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_misaligned,
   output logic [63:0]     fetch_count
);

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            kill_q, kill_d;
   logic [31:0]     inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            misaligned_q, misaligned_d;
   logic [63:0]     count_q, count_d;

   logic            req_acc;
   logic            redir_bad;

   assign imem_req_valid   = (state_q == REQ) && !rst;
   assign imem_req_addr    = pc_q;
   assign inst_valid       = (state_q == HOLD) && !rst;
   assign inst             = inst_q;
   assign inst_pc          = inst_pc_q;
   assign fetch_misaligned = misaligned_q;
   assign fetch_count      = count_q;

   assign req_acc   = imem_req_valid && imem_req_ready;
   assign redir_bad = redirect_pc[1:0] != 2'b00;

   // Next-state and datapath updates; a redirect always wins over the sequential pc+4.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      kill_d       = kill_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      misaligned_d = misaligned_q;
      count_d      = count_q;

      unique case (state_q)
         REQ: begin
            if (redirect_valid) begin
               if (redir_bad) begin
                  // Any response to a request accepted now is ignored in ERR.
                  misaligned_d = 1'b1;
                  state_d      = ERR;
               end else begin
                  pc_d = redirect_pc;
                  if (req_acc) begin
                     kill_d  = 1'b1;
                     state_d = WAIT;
                  end
               end
            end else if (req_acc) begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (redirect_valid) begin
               if (redir_bad) begin
                  misaligned_d = 1'b1;
                  state_d      = ERR;
               end else begin
                  pc_d = redirect_pc;
                  if (imem_resp_valid) begin
                     // The in-flight word belongs to the old path; drop it now.
                     kill_d  = 1'b0;
                     state_d = REQ;
                  end else begin
                     kill_d = 1'b1;
                  end
               end
            end else if (imem_resp_valid) begin
               if (kill_q) begin
                  // pc already holds the redirect target.
                  kill_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  inst_d    = imem_resp_data;
                  inst_pc_d = pc_q;
                  state_d   = HOLD;
               end
            end
         end

         HOLD: begin
            // A handshake coinciding with a redirect still counts: that word is the jump.
            if (inst_ready) begin
               count_d = count_q + 64'd1;
            end
            if (redirect_valid) begin
               if (redir_bad) begin
                  misaligned_d = 1'b1;
                  state_d      = ERR;
               end else begin
                  pc_d    = redirect_pc;
                  state_d = REQ;
               end
            end else if (inst_ready) begin
               pc_d    = pc_q + XLEN'(4);
               state_d = REQ;
            end
         end

         ERR: begin
            // Terminal until reset; responses and redirects ignored.
            state_d = ERR;
         end

         default: begin
            state_d = REQ;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= REQ;
         pc_q         <= RESET_PC;
         kill_q       <= 1'b0;
         inst_q       <= 32'd0;
         inst_pc_q    <= '0;
         misaligned_q <= 1'b0;
         count_q      <= 64'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         kill_q       <= kill_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         misaligned_q <= misaligned_d;
         count_q      <= count_d;
      end
   end

endmodule
